// File: rtl/wb_trd.sv
// ---------------------------------------------------------------------------
// wb_trd : write-back stage of the 8-thread pipeline.
//
// Takes the registered outputs of the memory-access stage, picks the
// register-file write data (execute result or load data), drives the single
// register-file write port, and owns the thread-status table. Thread-control
// ops (START/KILL/EXIT) update that table; START requests are queued as
// pending bits and handed to fetch one at a time through a round-robin
// valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ins_wb              instruction word, 0 marks a bubble
//   pc_wb               instruction PC, debug visibility only
//   exe_data_wb         execute result
//   trd_wb              issuing thread
//   reg_wr_wb           destination register
//   wr_en_wb            register write enable
//   wb_sel_wb           write-data select (0 execute, 1 load data)
//   d_rd_data           data-memory read data
//   trd_ctrl_wb         thread op (none/START/KILL/EXIT)
//   obj_trd_wb          target thread of START/KILL
//   new_pc_wb           START entry PC
//   new_data_wb         START argument
//   rf_wr_*             register-file write port (data is also forwarded)
//   start_vld/rdy/...   start request handshake towards fetch
//   kill_vld, kill_trd  one-cycle squash pulse towards fetch
//   trd_active          thread-status table
//   err_start           one-cycle pulse: START hit an already-active thread
//   halt                every thread is inactive (sticky until reset)
// ---------------------------------------------------------------------------
module wb_trd #(
   parameter int         NTRD       = 8,
   parameter logic [7:0] RST_ACTIVE = 8'h01
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ins_wb,
   input  logic [31:0] pc_wb,
   input  logic [31:0] exe_data_wb,
   input  logic [2:0]  trd_wb,
   input  logic [4:0]  reg_wr_wb,
   input  logic        wr_en_wb,
   input  logic        wb_sel_wb,
   input  logic [31:0] d_rd_data,
   input  logic [2:0]  trd_ctrl_wb,
   input  logic [2:0]  obj_trd_wb,
   input  logic [31:0] new_pc_wb,
   input  logic [31:0] new_data_wb,
   output logic        rf_wr_en,
   output logic [2:0]  rf_wr_trd,
   output logic [4:0]  rf_wr_addr,
   output logic [31:0] rf_wr_data,
   output logic        start_vld,
   input  logic        start_rdy,
   output logic [2:0]  start_trd,
   output logic [31:0] start_pc,
   output logic [31:0] start_arg,
   output logic        kill_vld,
   output logic [2:0]  kill_trd,
   output logic [7:0]  trd_active,
   output logic        err_start,
   output logic        halt
);

   typedef enum logic [2:0] {
      OP_NONE  = 3'b000,
      OP_START = 3'b001,
      OP_KILL  = 3'b010,
      OP_EXIT  = 3'b011
   } trd_op_e;

   logic [NTRD-1:0] active_q, active_d;
   logic [NTRD-1:0] pending_q, pending_d;
   logic [2:0]      rr_ptr_q, rr_ptr_d;
   logic            kill_vld_q, kill_vld_d;
   logic [2:0]      kill_trd_q, kill_trd_d;
   logic            err_start_q, err_start_d;
   logic            halt_q, halt_d;
   logic [31:0]     pc_q  [NTRD];
   logic [31:0]     pc_d  [NTRD];
   logic [31:0]     arg_q [NTRD];
   logic [31:0]     arg_d [NTRD];

   logic [2:0]      arb_trd;
   logic            handshake;

   // The PC is carried along for debug only and has no function here.
   logic unused_pc;
   assign unused_pc = ^pc_wb;

   // Register-file write port: zero latency, r0 writes are dropped.
   always_comb begin
      rf_wr_data = wb_sel_wb ? d_rd_data : exe_data_wb;
      rf_wr_en   = wr_en_wb & (reg_wr_wb != 5'd0);
      rf_wr_trd  = trd_wb;
      rf_wr_addr = reg_wr_wb;
   end

   // Round-robin pick: the first pending thread found scanning upward from
   // rr_ptr, wrapping 7 -> 0. Purely a function of registers, so the request
   // holds steady while fetch is stalling.
   always_comb begin
      logic       found;
      logic [2:0] idx;
      found   = 1'b0;
      idx     = rr_ptr_q;
      arb_trd = rr_ptr_q;
      for (int i = 0; i < NTRD; i++) begin
         idx = rr_ptr_q + 3'(i);
         if (!found && pending_q[idx]) begin
            found   = 1'b1;
            arb_trd = idx;
         end
      end
   end

   assign start_vld = |pending_q;
   assign start_trd = arb_trd;
   assign start_pc  = pc_q[arb_trd];
   assign start_arg = arg_q[arb_trd];
   assign handshake = start_vld & start_rdy;

   // Next-state for the thread table. The handshake is applied first so that
   // a KILL/EXIT of the thread being started in the same cycle still clears
   // it; the kill pulse then lets fetch squash that freshly started thread.
   always_comb begin
      logic [2:0] tgt;
      active_d    = active_q;
      pending_d   = pending_q;
      rr_ptr_d    = rr_ptr_q;
      kill_vld_d  = 1'b0;
      kill_trd_d  = kill_trd_q;
      err_start_d = 1'b0;
      halt_d      = halt_q | (active_q == '0);
      pc_d        = pc_q;
      arg_d       = arg_q;
      tgt         = (trd_ctrl_wb == OP_EXIT) ? trd_wb : obj_trd_wb;

      if (handshake) begin
         pending_d[arb_trd] = 1'b0;
         rr_ptr_d           = arb_trd + 3'd1;
      end

      // A bubble (ins_wb == 0) never carries a thread op.
      if (ins_wb != 32'd0) begin
         case (trd_ctrl_wb)
            OP_START: begin
               if (active_q[tgt]) begin
                  err_start_d = 1'b1;
               end else begin
                  active_d[tgt]  = 1'b1;
                  pending_d[tgt] = 1'b1;
                  pc_d[tgt]      = new_pc_wb;
                  arg_d[tgt]     = new_data_wb;
               end
            end
            OP_KILL, OP_EXIT: begin
               active_d[tgt]  = 1'b0;
               pending_d[tgt] = 1'b0;
               kill_vld_d     = 1'b1;
               kill_trd_d     = tgt;
            end
            default: ;
         endcase
      end
   end

   // State registers; reset also drops every pending start, which pulls
   // start_vld low without waiting for a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q    <= RST_ACTIVE[NTRD-1:0];
         pending_q   <= '0;
         rr_ptr_q    <= 3'd0;
         kill_vld_q  <= 1'b0;
         kill_trd_q  <= 3'd0;
         err_start_q <= 1'b0;
         halt_q      <= 1'b0;
         for (int i = 0; i < NTRD; i++) begin
            pc_q[i]  <= 32'd0;
            arg_q[i] <= 32'd0;
         end
      end else begin
         active_q    <= active_d;
         pending_q   <= pending_d;
         rr_ptr_q    <= rr_ptr_d;
         kill_vld_q  <= kill_vld_d;
         kill_trd_q  <= kill_trd_d;
         err_start_q <= err_start_d;
         halt_q      <= halt_d;
         for (int i = 0; i < NTRD; i++) begin
            pc_q[i]  <= pc_d[i];
            arg_q[i] <= arg_d[i];
         end
      end
   end

   assign trd_active = active_q;
   assign kill_vld   = kill_vld_q;
   assign kill_trd   = kill_trd_q;
   assign err_start  = err_start_q;
   assign halt       = halt_q;

endmodule

// File: tb/tb_wb_trd.sv
// ---------------------------------------------------------------------------
// tb_wb_trd : self-checking bench for wb_trd.
// Write-path behaviour is driven from a table of vectors; thread-control
// behaviour (START, round robin, KILL, EXIT/halt, async reset) is driven by
// hand-written cycle sequences with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_wb_trd;

   logic        clk;
   logic        rst_n;
   logic [31:0] ins_wb;
   logic [31:0] pc_wb;
   logic [31:0] exe_data_wb;
   logic [2:0]  trd_wb;
   logic [4:0]  reg_wr_wb;
   logic        wr_en_wb;
   logic        wb_sel_wb;
   logic [31:0] d_rd_data;
   logic [2:0]  trd_ctrl_wb;
   logic [2:0]  obj_trd_wb;
   logic [31:0] new_pc_wb;
   logic [31:0] new_data_wb;
   logic        rf_wr_en;
   logic [2:0]  rf_wr_trd;
   logic [4:0]  rf_wr_addr;
   logic [31:0] rf_wr_data;
   logic        start_vld;
   logic        start_rdy;
   logic [2:0]  start_trd;
   logic [31:0] start_pc;
   logic [31:0] start_arg;
   logic        kill_vld;
   logic [2:0]  kill_trd;
   logic [7:0]  trd_active;
   logic        err_start;
   logic        halt;

   int total;
   int bad;

   localparam logic [2:0] OP_NONE  = 3'b000;
   localparam logic [2:0] OP_START = 3'b001;
   localparam logic [2:0] OP_KILL  = 3'b010;
   localparam logic [2:0] OP_EXIT  = 3'b011;

   typedef struct {
      logic        wr_en;
      logic [4:0]  reg_wr;
      logic [2:0]  trd;
      logic        sel;
      logic [31:0] exe;
      logic [31:0] rd;
      logic        exp_en;
      logic [31:0] exp_data;
   } wr_vec_t;

   wr_vec_t vecs [6];

   wb_trd dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ins_wb      (ins_wb),
      .pc_wb       (pc_wb),
      .exe_data_wb (exe_data_wb),
      .trd_wb      (trd_wb),
      .reg_wr_wb   (reg_wr_wb),
      .wr_en_wb    (wr_en_wb),
      .wb_sel_wb   (wb_sel_wb),
      .d_rd_data   (d_rd_data),
      .trd_ctrl_wb (trd_ctrl_wb),
      .obj_trd_wb  (obj_trd_wb),
      .new_pc_wb   (new_pc_wb),
      .new_data_wb (new_data_wb),
      .rf_wr_en    (rf_wr_en),
      .rf_wr_trd   (rf_wr_trd),
      .rf_wr_addr  (rf_wr_addr),
      .rf_wr_data  (rf_wr_data),
      .start_vld   (start_vld),
      .start_rdy   (start_rdy),
      .start_trd   (start_trd),
      .start_pc    (start_pc),
      .start_arg   (start_arg),
      .kill_vld    (kill_vld),
      .kill_trd    (kill_trd),
      .trd_active  (trd_active),
      .err_start   (err_start),
      .halt        (halt)
   );

   // 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it, and reports a mismatch on a single line.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge, away from the edge itself.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive a thread-control op for the coming edge; a none op is a bubble.
   task automatic applyStimulus(input logic [2:0] ctrl, input logic [2:0] trd,
                                input logic [2:0] obj, input logic [31:0] npc,
                                input logic [31:0] ndata);
      ins_wb      = (ctrl == OP_NONE) ? 32'd0 : 32'h0000_0073;
      pc_wb       = 32'h0000_4000;
      trd_ctrl_wb = ctrl;
      trd_wb      = trd;
      obj_trd_wb  = obj;
      new_pc_wb   = npc;
      new_data_wb = ndata;
      wr_en_wb    = 1'b0;
      reg_wr_wb   = 5'd0;
      wb_sel_wb   = 1'b0;
      exe_data_wb = 32'd0;
      d_rd_data   = 32'd0;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      start_rdy = 1'b0;
      applyStimulus(OP_NONE, 3'd0, 3'd0, 32'd0, 32'd0);

      vecs[0] = '{1'b1, 5'd5,  3'd2, 1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF};
      vecs[1] = '{1'b1, 5'd0,  3'd2, 1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
      vecs[2] = '{1'b1, 5'd31, 3'd7, 1'b0, 32'hCAFE_0001, 32'hDEAD_BEEF, 1'b1, 32'hCAFE_0001};
      vecs[3] = '{1'b0, 5'd7,  3'd1, 1'b0, 32'h5555_AAAA, 32'h0F0F_0F0F, 1'b0, 32'h5555_AAAA};
      vecs[4] = '{1'b1, 5'd1,  3'd4, 1'b1, 32'h0000_0000, 32'h8000_0001, 1'b1, 32'h8000_0001};
      vecs[5] = '{1'b0, 5'd0,  3'd0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000};

      // Reset state.
      doReset();
      checkOutput("rst_active", {24'd0, trd_active}, 32'h01);
      checkOutput("rst_start_vld", {31'd0, start_vld}, 32'd0);
      checkOutput("rst_kill_vld", {31'd0, kill_vld}, 32'd0);
      checkOutput("rst_err", {31'd0, err_start}, 32'd0);
      checkOutput("rst_halt", {31'd0, halt}, 32'd0);

      // Write path, table driven.
      for (int i = 0; i < 6; i++) begin
         ins_wb      = (i == 5) ? 32'd0 : 32'h0000_0033;
         wr_en_wb    = vecs[i].wr_en;
         reg_wr_wb   = vecs[i].reg_wr;
         trd_wb      = vecs[i].trd;
         wb_sel_wb   = vecs[i].sel;
         exe_data_wb = vecs[i].exe;
         d_rd_data   = vecs[i].rd;
         #1;
         checkOutput($sformatf("wr_en[%0d]", i), {31'd0, rf_wr_en}, {31'd0, vecs[i].exp_en});
         checkOutput($sformatf("wr_data[%0d]", i), rf_wr_data, vecs[i].exp_data);
         checkOutput($sformatf("wr_addr[%0d]", i), {27'd0, rf_wr_addr}, {27'd0, vecs[i].reg_wr});
         checkOutput($sformatf("wr_trd[%0d]", i), {29'd0, rf_wr_trd}, {29'd0, vecs[i].trd});
         step();
         checkOutput($sformatf("wr_no_op[%0d]", i), {24'd0, trd_active}, 32'h01);
      end

      // START thread 3 while fetch stalls; request must hold.
      applyStimulus(OP_START, 3'd0, 3'd3, 32'h100, 32'd7);
      step();
      applyStimulus(OP_NONE, 3'd0, 3'd0, 32'd0, 32'd0);
      checkOutput("st3_active", {24'd0, trd_active}, 32'h09);
      checkOutput("st3_vld", {31'd0, start_vld}, 32'd1);
      checkOutput("st3_trd", {29'd0, start_trd}, 32'd3);
      checkOutput("st3_pc", start_pc, 32'h100);
      checkOutput("st3_arg", start_arg, 32'd7);
      step();
      step();
      checkOutput("st3_hold_vld", {31'd0, start_vld}, 32'd1);
      checkOutput("st3_hold_trd", {29'd0, start_trd}, 32'd3);
      checkOutput("st3_hold_pc", start_pc, 32'h100);
      start_rdy = 1'b1;
      step();
      start_rdy = 1'b0;
      checkOutput("st3_accepted", {31'd0, start_vld}, 32'd0);

      // START of an already-active thread.
      applyStimulus(OP_START, 3'd3, 3'd0, 32'h200, 32'd9);
      step();
      applyStimulus(OP_NONE, 3'd0, 3'd0, 32'd0, 32'd0);
      checkOutput("err_pulse", {31'd0, err_start}, 32'd1);
      checkOutput("err_active", {24'd0, trd_active}, 32'h09);
      checkOutput("err_no_pending", {31'd0, start_vld}, 32'd0);
      step();
      checkOutput("err_one_cycle", {31'd0, err_start}, 32'd0);

      // Round robin with fetch always ready: 2, 5, 6 served in order.
      start_rdy = 1'b1;
      applyStimulus(OP_START, 3'd0, 3'd2, 32'h220, 32'd2);
      step();
      checkOutput("rr_first", {29'd0, start_trd}, 32'd2);
      applyStimulus(OP_START, 3'd0, 3'd5, 32'h550, 32'd5);
      step();
      checkOutput("rr_second", {29'd0, start_trd}, 32'd5);
      checkOutput("rr_second_pc", start_pc, 32'h550);
      applyStimulus(OP_START, 3'd0, 3'd6, 32'h660, 32'd6);
      step();
      checkOutput("rr_third", {29'd0, start_trd}, 32'd6);
      checkOutput("rr_third_arg", start_arg, 32'd6);
      applyStimulus(OP_NONE, 3'd0, 3'd0, 32'd0, 32'd0);
      step();
      checkOutput("rr_drained", {31'd0, start_vld}, 32'd0);
      checkOutput("rr_active", {24'd0, trd_active}, 32'h6D);

      // KILL 2, then re-START 2 and START 1 while stalled; rr_ptr is 7 so the
      // scan wraps and serves 1 before 2.
      applyStimulus(OP_KILL, 3'd0, 3'd2, 32'd0, 32'd0);
      step();
      checkOutput("k2_vld", {31'd0, kill_vld}, 32'd1);
      checkOutput("k2_trd", {29'd0, kill_trd}, 32'd2);
      checkOutput("k2_active", {24'd0, trd_active}, 32'h69);
      start_rdy = 1'b0;
      applyStimulus(OP_START, 3'd0, 3'd2, 32'h2220, 32'd22);
      step();
      checkOutput("k2_pulse_end", {31'd0, kill_vld}, 32'd0);
      applyStimulus(OP_START, 3'd0, 3'd1, 32'h1110, 32'd11);
      step();
      applyStimulus(OP_NONE, 3'd0, 3'd0, 32'd0, 32'd0);
      checkOutput("wrap_first", {29'd0, start_trd}, 32'd1);
      checkOutput("wrap_active", {24'd0, trd_active}, 32'h6F);
      start_rdy = 1'b1;
      step();
      checkOutput("wrap_second", {29'd0, start_trd}, 32'd2);
      checkOutput("wrap_second_pc", start_pc, 32'h2220);
      step();
      start_rdy = 1'b0;
      checkOutput("wrap_drained", {31'd0, start_vld}, 32'd0);

      // KILL a pending thread before fetch accepts it.
      applyStimulus(OP_START, 3'd0, 3'd4, 32'h440, 32'd4);
      step();
      checkOutput("k4_pending", {29'd0, start_trd}, 32'd4);
      applyStimulus(OP_KILL, 3'd0, 3'd4, 32'd0, 32'd0);
      step();
      applyStimulus(OP_NONE, 3'd0, 3'd0, 32'd0, 32'd0);
      checkOutput("k4_vld", {31'd0, kill_vld}, 32'd1);
      checkOutput("k4_trd", {29'd0, kill_trd}, 32'd4);
      checkOutput("k4_no_start", {31'd0, start_vld}, 32'd0);
      checkOutput("k4_active", {24'd0, trd_active}, 32'h6F);
      step();
      checkOutput("k4_pulse_end", {31'd0, kill_vld}, 32'd0);

      // Leave only thread 0, then EXIT it: halt follows one cycle later.
      foreach (vecs[i]) begin
         if (i < 5) begin
            applyStimulus(OP_KILL, 3'd0, (i < 3) ? 3'(i + 1) : 3'(i + 2), 32'd0, 32'd0);
            step();
         end
      end
      checkOutput("solo_active", {24'd0, trd_active}, 32'h01);
      applyStimulus(OP_EXIT, 3'd0, 3'd6, 32'd0, 32'd0);
      step();
      applyStimulus(OP_NONE, 3'd0, 3'd0, 32'd0, 32'd0);
      checkOutput("exit_vld", {31'd0, kill_vld}, 32'd1);
      checkOutput("exit_trd", {29'd0, kill_trd}, 32'd0);
      checkOutput("exit_active", {24'd0, trd_active}, 32'h00);
      checkOutput("exit_halt_early", {31'd0, halt}, 32'd0);
      step();
      checkOutput("halt_set", {31'd0, halt}, 32'd1);
      step();
      step();
      checkOutput("halt_sticky", {31'd0, halt}, 32'd1);

      // Handshake and KILL of the same thread in one cycle.
      doReset();
      checkOutput("rst2_halt", {31'd0, halt}, 32'd0);
      applyStimulus(OP_START, 3'd0, 3'd5, 32'h5000, 32'd50);
      step();
      start_rdy = 1'b1;
      applyStimulus(OP_KILL, 3'd0, 3'd5, 32'd0, 32'd0);
      step();
      start_rdy = 1'b0;
      applyStimulus(OP_NONE, 3'd0, 3'd0, 32'd0, 32'd0);
      checkOutput("hk_active", {24'd0, trd_active}, 32'h01);
      checkOutput("hk_vld", {31'd0, start_vld}, 32'd0);
      checkOutput("hk_kill", {31'd0, kill_vld}, 32'd1);
      checkOutput("hk_kill_trd", {29'd0, kill_trd}, 32'd5);

      // Asynchronous reset in the middle of a pending request.
      applyStimulus(OP_START, 3'd0, 3'd6, 32'h6000, 32'd60);
      step();
      applyStimulus(OP_NONE, 3'd0, 3'd0, 32'd0, 32'd0);
      checkOutput("pre_rst_vld", {31'd0, start_vld}, 32'd1);
      checkOutput("pre_rst_active", {24'd0, trd_active}, 32'h41);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_active", {24'd0, trd_active}, 32'h01);
      checkOutput("async_rst_vld", {31'd0, start_vld}, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      checkOutput("post_rst_vld", {31'd0, start_vld}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
